// File: rtl/ieeedrv_trkbuf_ctrl.sv
// Track buffer sequencer for one IEEE drive unit: waits for a stable track/head/sub-drive
// request, writes a dirty resident track back to SD, then loads the requested track.
module ieeedrv_trkbuf_ctrl #(
    parameter int          SUBDRV     = 2,
    parameter logic [15:0] SETTLE_CYC = 16'd4000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic        drv_act,
    input  logic        drv_hd,
    input  logic [7:0]  track,
    input  logic        buf_we,
    input  logic [31:0] lba_base,
    input  logic [4:0]  blk_cnt,
    output logic        req_drv,
    output logic        req_hd,
    output logic [7:0]  req_trk,
    output logic [31:0] sd_lba,
    output logic [3:0]  sd_blk,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic        busy,
    output logic        loaded
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_WB_REQ = 3'd2;
    localparam logic [2:0] ST_WB_ACK = 3'd3;
    localparam logic [2:0] ST_RD_REQ = 3'd4;
    localparam logic [2:0] ST_RD_ACK = 3'd5;

    logic [2:0]  state;
    logic        res_drv;
    logic        res_hd;
    logic [7:0]  res_trk;
    logic        dirty;
    logic [15:0] settle_cnt;
    logic [4:0]  blk;
    logic [9:0]  prev_tag;
    logic        mnt_q;
    logic        ack_idle;

    logic        cur_drv;
    logic [9:0]  cur_tag;
    logic [9:0]  res_tag;
    logic [9:0]  out_tag;
    logic        req_chg;
    logic        settle_done;
    logic [4:0]  blk_last;
    logic        last_blk;
    logic        mnt_fall;
    logic        mnt_rise;

    assign cur_drv     = (SUBDRV > 1) ? drv_act : 1'b0;
    assign cur_tag     = {cur_drv, drv_hd, track};
    assign res_tag     = {res_drv, res_hd, res_trk};
    assign out_tag     = {req_drv, req_hd, req_trk};
    assign req_chg     = (cur_tag != prev_tag);
    assign settle_done = !req_chg && (settle_cnt == SETTLE_CYC - 16'd1);
    assign blk_last    = (blk_cnt == 5'd0) ? 5'd0 : blk_cnt - 5'd1;
    assign last_blk    = (blk == blk_last);
    assign mnt_fall    = mnt_q && !img_mounted;
    assign mnt_rise    = !mnt_q && img_mounted;

    // NOTE: all state lives in one clocked block with non-blocking assignments; where two
    // branches write the same register in a cycle, the later assignment intentionally wins.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= ST_IDLE;
            res_drv    <= 1'b0;
            res_hd     <= 1'b0;
            res_trk    <= 8'hFF;
            dirty      <= 1'b0;
            settle_cnt <= '0;
            blk        <= '0;
            prev_tag   <= '0;
            mnt_q      <= 1'b0;
            ack_idle   <= 1'b0;
            req_drv    <= 1'b0;
            req_hd     <= 1'b0;
            req_trk    <= '0;
            sd_lba     <= '0;
            sd_blk     <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            busy       <= 1'b0;
            loaded     <= 1'b0;
        end else begin
            mnt_q    <= img_mounted;
            prev_tag <= cur_tag;

            // A transfer abandoned by reset or unmount may still hold sd_ack high.
            if (mnt_fall)
                ack_idle <= 1'b0;
            else if (!sd_ack)
                ack_idle <= 1'b1;

            if (req_chg)
                settle_cnt <= '0;
            else if (state == ST_SETTLE && !settle_done)
                settle_cnt <= settle_cnt + 16'd1;

            if (!img_mounted) begin
                state                     <= ST_IDLE;
                loaded                    <= 1'b0;
                dirty                     <= 1'b0;
                sd_rd                     <= 1'b0;
                sd_wr                     <= 1'b0;
                blk                       <= '0;
                {req_drv, req_hd, req_trk} <= cur_tag;
                if (mnt_fall)
                    busy <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        {req_drv, req_hd, req_trk} <= cur_tag;
                        if (buf_we && loaded && !img_readonly)
                            dirty <= 1'b1;
                        if (mnt_rise) begin
                            res_trk <= 8'hFF;
                            loaded  <= 1'b0;
                        end else if (cur_tag != res_tag) begin
                            busy       <= 1'b1;
                            loaded     <= 1'b0;
                            settle_cnt <= '0;
                            state      <= ST_SETTLE;
                        end
                    end

                    ST_SETTLE: begin
                        {req_drv, req_hd, req_trk} <= cur_tag;
                        if (settle_done) begin
                            if (cur_tag == res_tag && res_trk != 8'hFF) begin
                                // Request came back to the resident track: contents still valid.
                                loaded <= 1'b1;
                                busy   <= 1'b0;
                                state  <= ST_IDLE;
                            end else if (dirty && !img_readonly) begin
                                {req_drv, req_hd, req_trk} <= res_tag;
                                blk   <= '0;
                                state <= ST_WB_REQ;
                            end else if (track == 8'hFF) begin
                                {res_drv, res_hd, res_trk} <= cur_tag;
                                dirty <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                // The buffer is about to be overwritten, so the old tag is void.
                                {req_drv, req_hd, req_trk} <= cur_tag;
                                res_trk <= 8'hFF;
                                dirty   <= 1'b0;
                                blk     <= '0;
                                state   <= ST_RD_REQ;
                            end
                        end
                    end

                    ST_WB_REQ: begin
                        if (!sd_wr) begin
                            if (ack_idle) begin
                                sd_wr  <= 1'b1;
                                sd_lba <= lba_base + {27'd0, blk};
                                sd_blk <= blk[3:0];
                            end
                        end else if (sd_ack) begin
                            sd_wr <= 1'b0;
                            state <= ST_WB_ACK;
                        end
                    end

                    ST_WB_ACK: begin
                        if (!sd_ack) begin
                            if (last_blk) begin
                                dirty <= 1'b0;
                                blk   <= '0;
                                state <= ST_SETTLE;
                            end else begin
                                blk   <= blk + 5'd1;
                                state <= ST_WB_REQ;
                            end
                        end
                    end

                    ST_RD_REQ: begin
                        if (!sd_rd) begin
                            if (ack_idle) begin
                                sd_rd  <= 1'b1;
                                sd_lba <= lba_base + {27'd0, blk};
                                sd_blk <= blk[3:0];
                            end
                        end else if (sd_ack) begin
                            sd_rd <= 1'b0;
                            state <= ST_RD_ACK;
                        end
                    end

                    ST_RD_ACK: begin
                        if (!sd_ack) begin
                            if (last_blk) begin
                                {res_drv, res_hd, res_trk} <= out_tag;
                                loaded <= 1'b1;
                                busy   <= 1'b0;
                                blk    <= '0;
                                state  <= ST_IDLE;
                            end else if (cur_tag != out_tag) begin
                                blk        <= '0;
                                settle_cnt <= '0;
                                state      <= ST_SETTLE;
                            end else begin
                                blk   <= blk + 5'd1;
                                state <= ST_RD_REQ;
                            end
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ieeedrv_trkbuf_ctrl.sv
// Self-checking bench for ieeedrv_trkbuf_ctrl: an HPS responder logs every SD block
// transfer, and a track-level model of the buffer predicts the expected transfer list.
module tb_ieeedrv_trkbuf_ctrl;

    localparam logic [15:0] SETTLE = 16'd40;

    logic        clk_sys;
    logic        reset;
    logic        img_mounted;
    logic        img_readonly;
    logic        drv_act;
    logic        drv_hd;
    logic [7:0]  track;
    logic        buf_we;
    logic [31:0] lba_base;
    logic [4:0]  blk_cnt;
    logic        req_drv;
    logic        req_hd;
    logic [7:0]  req_trk;
    logic [31:0] sd_lba;
    logic [3:0]  sd_blk;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic        busy;
    logic        loaded;

    ieeedrv_trkbuf_ctrl #(.SUBDRV(2), .SETTLE_CYC(SETTLE)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .drv_act      (drv_act),
        .drv_hd       (drv_hd),
        .track        (track),
        .buf_we       (buf_we),
        .lba_base     (lba_base),
        .blk_cnt      (blk_cnt),
        .req_drv      (req_drv),
        .req_hd       (req_hd),
        .req_trk      (req_trk),
        .sd_lba       (sd_lba),
        .sd_blk       (sd_blk),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .busy         (busy),
        .loaded       (loaded)
    );

    typedef struct {
        logic        wr;
        logic [31:0] lba;
        logic [3:0]  blk;
    } xfer_t;

    xfer_t       log_q[$];
    xfer_t       exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          ack_hold = 0;
    logic [31:0] drv_base[2];
    logic [4:0]  spt;

    // Track-level model of what the buffer holds.
    logic        m_valid = 1'b0;
    logic        m_dirty = 1'b0;
    logic        m_drv   = 1'b0;
    logic        m_hd    = 1'b0;
    logic [7:0]  m_trk   = 8'hFF;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Disk image layout: each sub-drive has its own base, head 1 lives 0x800 blocks further.
    function automatic logic [31:0] lba_of(input logic d, input logic h, input logic [7:0] t);
        return drv_base[d] + (h ? 32'h800 : 32'h0) + 32'(t) * 32'(spt);
    endfunction

    always_comb begin
        lba_base = lba_of(req_drv, req_hd, req_trk);
        blk_cnt  = spt;
    end

    // HPS responder: acknowledges each request after a random delay and logs it.
    initial begin : hps
        sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr) begin
                repeat ($urandom_range(0, 3)) @(negedge clk_sys);
                if (sd_rd || sd_wr) begin
                    log_q.push_back('{wr: sd_wr, lba: sd_lba, blk: sd_blk});
                    sd_ack = 1'b1;
                    repeat ((ack_hold != 0) ? ack_hold : int'($urandom_range(1, 4))) @(negedge clk_sys);
                    sd_ack = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_run(input logic wr, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{wr: wr, lba: base + 32'(i), blk: 4'(i)});
    endtask

    task automatic model_request(input logic d, input logic h, input logic [7:0] t);
        int n;
        n = (spt == 5'd0) ? 1 : int'(spt);
        if (m_valid && m_drv == d && m_hd == h && m_trk == t)
            return;
        if (m_valid && m_dirty && !img_readonly)
            push_run(1'b1, lba_of(m_drv, m_hd, m_trk), n);
        push_run(1'b0, lba_of(d, h, t), n);
        m_valid = 1'b1;
        m_dirty = 1'b0;
        m_drv   = d;
        m_hd    = h;
        m_trk   = t;
    endtask

    task automatic set_req(input logic d, input logic h, input logic [7:0] t);
        drv_act = d;
        drv_hd  = h;
        track   = t;
        model_request(d, h, t);
    endtask

    task automatic pulse_we(input int k);
        for (int i = 0; i < k; i++) begin
            buf_we = 1'b1;
            @(negedge clk_sys);
            buf_we = 1'b0;
            @(negedge clk_sys);
        end
        if (k > 0 && m_valid && !img_readonly)
            m_dirty = 1'b1;
    endtask

    task automatic wait_loaded(input string tag);
        int n;
        n = 0;
        repeat (3) @(negedge clk_sys);
        while (!(loaded && !busy) && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        check({tag, "_loaded"}, 64'(loaded && !busy), 64'd1);
        check({tag, "_req_tag"}, 64'({req_drv, req_hd, req_trk}), 64'({m_drv, m_hd, m_trk}));
    endtask

    task automatic compare_log(input string tag);
        int n;
        check({tag, "_xfer_count"}, 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_xfer%0d", tag, i),
                  {27'd0, log_q[i].wr, log_q[i].lba, log_q[i].blk},
                  {27'd0, exp_q[i].wr, exp_q[i].lba, exp_q[i].blk});
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin : stim
        int          n;
        int          viol;
        logic        found;
        logic [7:0]  r_trk;
        logic        r_drv;
        logic        r_hd;

        reset        = 1'b1;
        img_mounted  = 1'b0;
        img_readonly = 1'b0;
        drv_act      = 1'b0;
        drv_hd       = 1'b0;
        track        = 8'hFF;
        buf_we       = 1'b0;
        spt          = 5'd11;
        drv_base[0]  = 32'h0000_00F5;
        drv_base[1]  = 32'h0000_4000;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_loaded", 64'(loaded), 64'd0);
        check("rst_sd_req", 64'({sd_rd, sd_wr}), 64'd0);
        check("rst_sd_lba", 64'({sd_lba, sd_blk}), 64'd0);
        check("rst_req",    64'({req_drv, req_hd, req_trk}), 64'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // 1: mount with track 1 -> 11 reads from 0x100 after settling
        set_req(1'b0, 1'b0, 8'd1);
        img_mounted = 1'b1;
        repeat (int'(SETTLE) - 4) @(negedge clk_sys);
        check("s1_no_early_xfer", 64'(log_q.size()), 64'd0);
        check("s1_busy_settling", 64'(busy), 64'd1);
        wait_loaded("s1");
        compare_log("s1");

        // 2: dirty track 1, move to track 2 -> write-back then reload
        pulse_we(3);
        set_req(1'b0, 1'b0, 8'd2);
        wait_loaded("s2");
        compare_log("s2");

        // 3: write-protected image suppresses write-back
        img_readonly = 1'b1;
        pulse_we(3);
        set_req(1'b0, 1'b0, 8'd3);
        wait_loaded("s3");
        compare_log("s3");
        img_readonly = 1'b0;

        // 4: dirty track 3, toggle 3->4->3 within half the settle time -> no SD traffic
        pulse_we(2);
        track = 8'd4;
        repeat (int'(SETTLE) / 4) @(negedge clk_sys);
        set_req(1'b0, 1'b0, 8'd3);
        check("s4_busy_during_toggle", 64'(busy), 64'd1);
        wait_loaded("s4");
        compare_log("s4");

        // 5: switch to track 6 (track 3 still dirty), change drive during read block 4
        set_req(1'b0, 1'b0, 8'd6);
        push_run(1'b1, lba_of(1'b0, 1'b0, 8'd3), 11);
        push_run(1'b0, lba_of(1'b0, 1'b0, 8'd6), 5);
        exp_q.delete();
        push_run(1'b1, lba_of(1'b0, 1'b0, 8'd3), 11);
        push_run(1'b0, lba_of(1'b0, 1'b0, 8'd6), 5);
        m_valid = 1'b0;
        m_dirty = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 3000) begin
            for (int i = 0; i < log_q.size(); i++)
                if (!log_q[i].wr && log_q[i].blk == 4'd4)
                    found = 1'b1;
            if (!found) begin
                @(negedge clk_sys);
                n++;
            end
        end
        check("s5_block4_seen", 64'(found), 64'd1);
        drv_act = 1'b1;
        model_request(1'b1, 1'b0, 8'd6);
        wait_loaded("s5");
        compare_log("s5");

        // 6: reset while the HPS holds sd_ack during a write-back
        pulse_we(1);
        ack_hold = 120;
        set_req(1'b1, 1'b1, 8'd9);
        found = 1'b0;
        n = 0;
        while (!found && n < 3000) begin
            if (sd_ack && log_q.size() > 0 && log_q[log_q.size() - 1].wr)
                found = 1'b1;
            else begin
                @(negedge clk_sys);
                n++;
            end
        end
        check("s6_wb_started", 64'(found), 64'd1);
        ack_hold = 0;
        reset = 1'b1;
        @(negedge clk_sys);
        check("s6_rst_outputs",
              {busy, loaded, sd_rd, sd_wr, sd_blk, req_drv, req_hd, req_trk, sd_lba},
              64'd0);
        reset = 1'b0;
        log_q.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_dirty = 1'b0;
        model_request(1'b1, 1'b1, 8'd9);
        viol = 0;
        n = 0;
        while (sd_ack && n < 1000) begin
            if (sd_rd || sd_wr)
                viol++;
            @(negedge clk_sys);
            n++;
        end
        check("s6_no_req_while_ack", 64'(viol), 64'd0);
        check("s6_ack_released", 64'(sd_ack), 64'd0);
        wait_loaded("s6");
        compare_log("s6");

        // Unmount: immediately unusable; remount forces a reload of the same track
        pulse_we(2);
        img_mounted = 1'b0;
        @(negedge clk_sys);
        check("umnt_state", 64'({loaded, busy, sd_rd, sd_wr}), 64'b0100);
        repeat (10) @(negedge clk_sys);
        check("umnt_no_xfer", 64'(log_q.size()), 64'd0);
        img_mounted = 1'b1;
        m_valid = 1'b0;
        m_dirty = 1'b0;
        model_request(1'b1, 1'b1, 8'd9);
        wait_loaded("remnt");
        compare_log("remnt");

        // Random requests, including blk_cnt=0 and a layout that wraps the 32-bit LBA
        for (int it = 0; it < 8; it++) begin
            if (it == 0) begin
                drv_base[0] = 32'hFFFF_FF00;
                spt = 5'd16;
            end else begin
                spt = (it == 1) ? 5'd0 : 5'($urandom_range(0, 16));
                drv_base[1] = $urandom;
            end
            img_readonly = ($urandom_range(0, 3) == 0);
            pulse_we($urandom_range(0, 3));
            r_drv = 1'($urandom_range(0, 1));
            r_hd  = 1'($urandom_range(0, 1));
            r_trk = 8'($urandom_range(0, 79));
            if (it == 0)
                r_drv = 1'b0;
            set_req(r_drv, r_hd, r_trk);
            wait_loaded($sformatf("rnd%0d", it));
            compare_log($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
